// File: rtl/rvga_membus_arbiter.sv
// Round-robin arbiter sharing one memory bus between the rvga instruction and data membus ports.
// One access outstanding; mem_* registered at grant, responses passed through combinationally.
module rvga_membus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int D_FIRST = 1,
  parameter int TIMEOUT = 1023
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                i_read_i,
  input  logic [ADDR_W-1:0]   i_addr_i,
  output logic [DATA_W-1:0]   i_rdata_o,
  output logic                i_resp_o,
  input  logic                d_read_i,
  input  logic                d_write_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  input  logic [DATA_W/8-1:0] d_wmask_i,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                d_resp_o,
  output logic                mem_read_o,
  output logic                mem_write_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wmask_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  input  logic                mem_resp_i,
  output logic                timeout_o,
  output logic                busy_o
);
  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_GNT_I, ST_GNT_D, ST_TURN} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_last_d;
  logic                r_mem_read;
  logic                r_mem_write;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [MASK_W-1:0]   r_mem_wmask;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_timeout;

  logic w_i_req;
  logic w_d_req;
  logic w_gnt_i;
  logic w_gnt_d;
  logic w_granted;
  logic w_expire;
  logic w_done;

  assign w_i_req   = i_read_i;
  assign w_d_req   = d_read_i | d_write_i;
  assign w_granted = (r_state == ST_GNT_I) || (r_state == ST_GNT_D);
  // A real response in the expiry cycle wins over the forced one.
  assign w_expire  = (TIMEOUT > 0) && w_granted && !mem_resp_i &&
                     (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_done    = w_granted && (mem_resp_i || w_expire);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_gnt_i   = 1'b0;
    w_gnt_d   = 1'b0;
    i_resp_o  = 1'b0;
    d_resp_o  = 1'b0;
    i_rdata_o = '0;
    d_rdata_o = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_i_req && w_d_req) begin
          w_gnt_d = !r_last_d;
          w_gnt_i = r_last_d;
        end else begin
          w_gnt_d = w_d_req;
          w_gnt_i = w_i_req;
        end
        if (w_gnt_d) begin
          w_next = ST_GNT_D;
        end else if (w_gnt_i) begin
          w_next = ST_GNT_I;
        end
      end
      ST_GNT_I: begin
        i_resp_o = w_done;
        if (mem_resp_i) begin
          i_rdata_o = mem_rdata_i;
        end
        if (w_done) begin
          w_next = ST_TURN;
        end
      end
      ST_GNT_D: begin
        d_resp_o = w_done;
        if (mem_resp_i) begin
          d_rdata_o = mem_rdata_i;
        end
        if (w_done) begin
          w_next = ST_TURN;
        end
      end
      ST_TURN: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_last_d    <= (D_FIRST == 0);
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wmask <= '0;
      r_cnt       <= '0;
      r_timeout   <= 1'b0;
    end else begin
      if (w_gnt_d) begin
        r_mem_read  <= d_read_i & ~d_write_i;
        r_mem_write <= d_write_i;
        r_mem_addr  <= d_addr_i;
        r_mem_wdata <= d_wdata_i;
        r_mem_wmask <= d_wmask_i;
      end else if (w_gnt_i) begin
        r_mem_read  <= 1'b1;
        r_mem_write <= 1'b0;
        r_mem_addr  <= i_addr_i;
        r_mem_wdata <= '0;
        r_mem_wmask <= '0;
      end else if (w_done) begin
        r_mem_read  <= 1'b0;
        r_mem_write <= 1'b0;
        r_last_d    <= (r_state == ST_GNT_D);
      end
      if (w_gnt_i || w_gnt_d) begin
        r_cnt <= '0;
      end else if (w_granted && (TIMEOUT > 0)) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_expire) begin
        r_timeout <= 1'b1;
      end
    end
  end

  // The flag is visible in the expiry cycle itself and sticky afterwards.
  assign timeout_o   = r_timeout | w_expire;
  assign busy_o      = (r_state != ST_IDLE);
  assign mem_read_o  = r_mem_read;
  assign mem_write_o = r_mem_write;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign mem_wmask_o = r_mem_wmask;
endmodule

// File: tb/tb_rvga_membus_arbiter.sv
// Self-checking bench for rvga_membus_arbiter: vector table, directed corner cases, random traffic.
module tb_rvga_membus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;
  localparam int TO = 15;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          i_read_i = 1'b0;
  logic [AW-1:0] i_addr_i = '0;
  logic          d_read_i = 1'b0;
  logic          d_write_i = 1'b0;
  logic [AW-1:0] d_addr_i = '0;
  logic [DW-1:0] d_wdata_i = '0;
  logic [MW-1:0] d_wmask_i = '0;
  logic [DW-1:0] mem_rdata_i = '0;
  logic          mem_resp_i = 1'b0;
  logic [DW-1:0] i_rdata_o, d_rdata_o, mem_wdata_o;
  logic [AW-1:0] mem_addr_o;
  logic [MW-1:0] mem_wmask_o;
  logic          i_resp_o, d_resp_o, mem_read_o, mem_write_o, timeout_o, busy_o;

  always #5 clk_i = ~clk_i;

  rvga_membus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .D_FIRST(1), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .i_read_i(i_read_i), .i_addr_i(i_addr_i), .i_rdata_o(i_rdata_o), .i_resp_o(i_resp_o),
    .d_read_i(d_read_i), .d_write_i(d_write_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_wmask_i(d_wmask_i), .d_rdata_o(d_rdata_o), .d_resp_o(d_resp_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o), .mem_rdata_i(mem_rdata_i),
    .mem_resp_i(mem_resp_i), .timeout_o(timeout_o), .busy_o(busy_o)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // memory model state
  bit mem_en = 1'b1;
  bit mem_rand = 1'b0;
  int mem_lat = 3;
  int mem_age = 0;
  int cur_lat = 1;
  int inj_cnt = 0;
  int inj_done = 0;

  // reference model state
  int            m_gnt = 0;            // 0 none, 1 I, 2 D
  bit            m_last_d = 1'b0;
  bit            m_to = 1'b0;
  int            last_resp = -100;
  int            g_age = 0;
  bit            prev_cmd = 1'b0;
  logic          g_rd, g_wr;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata;
  logic [MW-1:0] g_wmask;
  int            glog[$];
  int            glog_c[$];
  int            n_gnt_i = 0, n_gnt_d = 0, n_req_i = 0, n_req_d = 0;

  // requester state
  bit i_pend = 1'b0, d_pend = 1'b0;
  int i_rsp_cyc = -100, d_rsp_cyc = -100;
  int p_i = 0, p_d = 0;

  typedef struct {
    bit          ir;
    logic [31:0] ia;
    bit          dr;
    bit          dw;
    logic [31:0] da;
    logic [31:0] dd;
    logic [3:0]  dm;
    int          lat;
    int          first;
    int          ngr;
  } vec_t;
  vec_t tbl[7];

  function automatic logic [DW-1:0] rdfun(input logic [AW-1:0] a);
    if (a == 32'h100) return 32'hDEAD_BEEF;
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%b required=%b cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk_i); #1;
      mem_resp_i  = 1'b0;
      mem_rdata_i = '0;
      if (inj_cnt != inj_done) begin
        inj_done    = inj_cnt;
        mem_resp_i  = 1'b1;
        mem_rdata_i = 32'hFACE_CAFE;
      end else if (mem_en && rst_i && (mem_read_o || mem_write_o)) begin
        mem_age++;
        if (mem_age == 1) cur_lat = mem_rand ? int'($urandom_range(5, 1)) : mem_lat;
        if (mem_age >= cur_lat) begin
          mem_resp_i  = 1'b1;
          mem_rdata_i = rdfun(mem_addr_o);
          mem_age     = 0;
        end
      end else begin
        mem_age = 0;
      end
    end
  end

  task automatic monitor();
    bit            cmd, d_any, exp_d, exp_ir, exp_dr, expire, busy_exp;
    logic [DW-1:0] exp_rd;
    cmd   = mem_read_o | mem_write_o;
    d_any = d_read_i | d_write_i;
    if (m_gnt == 0 && cmd) begin
      if (prev_cmd) begin
        chkb("cmd_dropped_after_resp", cmd, 1'b0);
      end else if (!i_read_i && !d_any) begin
        chkb("spurious_grant", cmd, 1'b0);
      end else begin
        exp_d   = (i_read_i && d_any) ? !m_last_d : d_any;
        g_rd    = exp_d ? (d_read_i && !d_write_i) : 1'b1;
        g_wr    = exp_d ? d_write_i : 1'b0;
        g_addr  = exp_d ? d_addr_i : i_addr_i;
        g_wdata = d_wdata_i;
        g_wmask = d_wmask_i;
        chkb("gnt_read", mem_read_o, g_rd);
        chkb("gnt_write", mem_write_o, g_wr);
        chk("gnt_addr", mem_addr_o, g_addr);
        if (g_wr) begin
          chk("gnt_wdata", mem_wdata_o, g_wdata);
          chk("gnt_wmask", 32'(mem_wmask_o), 32'(g_wmask));
        end
        chkb("turn_gap", (cyc - last_resp) >= 3, 1'b1);
        m_gnt = exp_d ? 2 : 1;
        g_age = 0;
        glog.push_back(m_gnt);
        glog_c.push_back(cyc);
        if (exp_d) n_gnt_d++; else n_gnt_i++;
      end
    end else if (m_gnt != 0) begin
      chkb("hold_read", mem_read_o, g_rd);
      chkb("hold_write", mem_write_o, g_wr);
      chk("hold_addr", mem_addr_o, g_addr);
    end
    if (m_gnt != 0) g_age++;
    expire   = (m_gnt != 0) && !mem_resp_i && (g_age == TO);
    exp_ir   = (m_gnt == 1) && (mem_resp_i || expire);
    exp_dr   = (m_gnt == 2) && (mem_resp_i || expire);
    exp_rd   = mem_resp_i ? rdfun(g_addr) : '0;
    busy_exp = (m_gnt != 0) || (cyc == last_resp + 1);
    chkb("i_resp", i_resp_o, exp_ir);
    chkb("d_resp", d_resp_o, exp_dr);
    chk("i_rdata", i_rdata_o, (m_gnt == 1) ? exp_rd : '0);
    chk("d_rdata", d_rdata_o, (m_gnt == 2) ? exp_rd : '0);
    chkb("busy", busy_o, busy_exp);
    chkb("timeout_flag", timeout_o, m_to || expire);
    if (i_resp_o) i_rsp_cyc = cyc;
    if (d_resp_o) d_rsp_cyc = cyc;
    if (exp_ir || exp_dr) begin
      m_last_d  = (m_gnt == 2);
      m_gnt     = 0;
      last_resp = cyc;
    end
    if (expire) m_to = 1'b1;
    prev_cmd = cmd;
  endtask

  task automatic raise_i(input logic [AW-1:0] a);
    i_pend = 1'b1; i_read_i = 1'b1; i_addr_i = a; n_req_i++;
  endtask

  task automatic raise_d(input bit rd, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [MW-1:0] m);
    d_pend = 1'b1; d_read_i = rd; d_write_i = wr; d_addr_i = a;
    d_wdata_i = wd; d_wmask_i = m; n_req_d++;
  endtask

  task automatic drive();
    bit dropped;
    int k;
    dropped = 1'b0;
    if (i_pend && i_rsp_cyc == cyc - 1) begin
      i_pend = 1'b0; i_read_i = 1'b0; dropped = 1'b1;
    end
    if (!i_pend && !dropped && int'($urandom_range(99, 0)) < p_i)
      raise_i($urandom() & 32'hFFFF_FFFC);
    dropped = 1'b0;
    if (d_pend && d_rsp_cyc == cyc - 1) begin
      d_pend = 1'b0; d_read_i = 1'b0; d_write_i = 1'b0; dropped = 1'b1;
    end
    if (!d_pend && !dropped && int'($urandom_range(99, 0)) < p_d) begin
      k = int'($urandom_range(2, 0));
      raise_d(k != 1, k != 0, $urandom() & 32'hFFFF_FFFC, $urandom(), MW'($urandom()));
    end
  endtask

  task automatic step();
    @(posedge clk_i); #2;
    cyc++;
    monitor();
    #1;
    drive();
  endtask

  task automatic wait_quiet(input int budget, input string nm);
    int k;
    k = 0;
    while ((i_pend || d_pend || m_gnt != 0 || cyc <= last_resp + 1) && k < budget) begin
      step();
      k++;
    end
    chkb({nm, "_within_budget"}, k < budget, 1'b1);
  endtask

  initial begin
    int g0, c0;
    tbl[0] = '{1, 32'h100, 0, 0, 32'h0,   32'h0,         4'h0, 3, 1, 1};
    tbl[1] = '{1, 32'h104, 0, 1, 32'h200, 32'h1234_5678, 4'hF, 2, 2, 2};
    tbl[2] = '{0, 32'h0,   1, 0, 32'h300, 32'h0,         4'h0, 1, 2, 1};
    tbl[3] = '{1, 32'h108, 1, 0, 32'h304, 32'h0,         4'h0, 4, 1, 2};
    tbl[4] = '{1, 32'h10C, 1, 1, 32'h308, 32'hA5A5_A5A5, 4'h5, 2, 1, 2};
    tbl[5] = '{1, 32'h110, 0, 0, 32'h0,   32'h0,         4'h0, 3, 1, 1};
    tbl[6] = '{1, 32'h114, 0, 1, 32'h30C, 32'hCAFE_F00D, 4'h8, 1, 2, 2};

    #1;
    chkb("rst_mem_read", mem_read_o, 1'b0);
    chkb("rst_mem_write", mem_write_o, 1'b0);
    chk("rst_mem_addr", mem_addr_o, '0);
    chk("rst_mem_wdata", mem_wdata_o, '0);
    chk("rst_mem_wmask", 32'(mem_wmask_o), 32'h0);
    chkb("rst_i_resp", i_resp_o, 1'b0);
    chkb("rst_d_resp", d_resp_o, 1'b0);
    chkb("rst_busy", busy_o, 1'b0);
    chkb("rst_timeout", timeout_o, 1'b0);
    @(posedge clk_i); #3;
    rst_i = 1'b1;

    for (int v = 0; v < 7; v++) begin
      mem_lat = tbl[v].lat;
      g0 = glog.size();
      c0 = cyc;
      if (tbl[v].ir) raise_i(tbl[v].ia);
      if (tbl[v].dr || tbl[v].dw) raise_d(tbl[v].dr, tbl[v].dw, tbl[v].da, tbl[v].dd, tbl[v].dm);
      wait_quiet(200, "vec");
      chk("vec_ngrants", glog.size() - g0, tbl[v].ngr);
      chk("vec_first", glog[g0], tbl[v].first);
      chk("vec_req_to_mem_latency", glog_c[g0] - c0, 1);
    end

    g0 = glog.size();
    mem_rand = 1'b1;
    p_i = 100; p_d = 100;
    for (int k = 0; k < 400 && glog.size() < g0 + 8; k++) step();
    p_i = 0; p_d = 0;
    wait_quiet(200, "contend");
    chkb("contend_8_grants", glog.size() >= g0 + 8, 1'b1);
    chk("contend_first_is_d", glog[g0], 2);
    for (int k = g0 + 1; k < glog.size(); k++)
      chkb("contend_alternate", glog[k] != glog[k-1], 1'b1);

    p_i = 40; p_d = 40;
    for (int k = 0; k < 1500; k++) step();
    p_i = 0; p_d = 0;
    wait_quiet(200, "random");
    chk("random_i_one_grant_per_req", n_gnt_i, n_req_i);
    chk("random_d_one_grant_per_req", n_gnt_d, n_req_d);

    mem_en = 1'b0;
    raise_i(32'h400);
    wait_quiet(100, "timeout");
    chkb("timeout_sticky", timeout_o, 1'b1);
    mem_en = 1'b1;
    mem_rand = 1'b0;
    mem_lat = 2;
    g0 = glog.size();
    raise_d(1'b1, 1'b0, 32'h404, 32'h0, 4'h0);
    wait_quiet(100, "after_timeout");
    chk("after_timeout_served_d", glog[g0], 2);
    chkb("timeout_still_set", timeout_o, 1'b1);

    mem_en = 1'b0;
    raise_d(1'b0, 1'b1, 32'h500, 32'h0BAD_F00D, 4'h3);
    for (int k = 0; k < 20 && m_gnt != 2; k++) step();
    chkb("rst_test_in_gnt_d", mem_write_o, 1'b1);
    #1;
    rst_i = 1'b0;
    #1;
    chkb("async_rst_mem_write", mem_write_o, 1'b0);
    chkb("async_rst_busy", busy_o, 1'b0);
    chkb("async_rst_d_resp", d_resp_o, 1'b0);
    chkb("async_rst_i_resp", i_resp_o, 1'b0);
    chkb("async_rst_timeout", timeout_o, 1'b0);
    m_gnt = 0; m_last_d = 1'b0; m_to = 1'b0; prev_cmd = 1'b0; last_resp = -100;
    d_pend = 1'b0; d_read_i = 1'b0; d_write_i = 1'b0;
    step();
    step();
    rst_i = 1'b1;
    step();
    inj_cnt++;
    step();
    step();
    mem_en = 1'b1;
    g0 = glog.size();
    raise_i(32'h600);
    raise_d(1'b1, 1'b0, 32'h604, 32'h0, 4'h0);
    wait_quiet(100, "post_reset_tie");
    chk("post_reset_first_is_d", glog[g0], 2);
    chk("post_reset_second_is_i", glog[g0+1], 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_time_limit: simulation did not finish, cycle=%0d", cyc);
    $fatal(1, "time limit");
  end
endmodule

// File: doc/rvga_membus_arbiter.md
Name: rvga_membus_arbiter

Overview:
- Shares one physical memory bus (single DDR model or controller) between the instruction-fetch and data-access membus requesters of the rvga core.
- Sits between the core's imembus/dmembus ports and one downstream memory. Only one upstream request is outstanding at a time.
- Arbitration is round-robin with a configurable tie-break. A watchdog flags a memory that never responds.

Parameters:
- ADDR_W, 32, address width of all buses
- DATA_W, 32, data width of all buses (byte enables are DATA_W/8)
- D_FIRST, 1, winner on simultaneous requests when no history: 1 = data port, 0 = instruction port
- TIMEOUT, 1023, cycles a granted access may wait for mem_resp_i before timeout; 0 disables the watchdog

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous assert, active-low
- i_read_i  in  1  instruction read request, level, held until i_resp_o
- i_addr_i  in  ADDR_W  instruction address
- i_rdata_o  out  DATA_W  instruction read data, valid with i_resp_o
- i_resp_o  out  1  one-cycle completion pulse to the instruction port
- d_read_i  in  1  data read request, level
- d_write_i  in  1  data write request, level; read and write both high is illegal
- d_addr_i  in  ADDR_W  data address
- d_wdata_i  in  DATA_W  write data
- d_wmask_i  in  DATA_W/8  byte enables
- d_rdata_o  out  DATA_W  data read data, valid with d_resp_o
- d_resp_o  out  1  one-cycle completion pulse to the data port
- mem_read_o  out  1  downstream read, registered
- mem_write_o  out  1  downstream write, registered
- mem_addr_o  out  ADDR_W  downstream address, registered
- mem_wdata_o  out  DATA_W  downstream write data, registered
- mem_wmask_o  out  DATA_W/8  downstream byte enables, registered
- mem_rdata_i  in  DATA_W  downstream read data
- mem_resp_i  in  1  downstream completion pulse
- timeout_o  out  1  sticky watchdog error flag
- busy_o  out  1  high while state is not IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE; last-grant pointer set so that the D_FIRST side wins the first tie; watchdog counter 0.
- Reset mid-access: the in-flight access is abandoned. No resp is issued to either port. A mem_resp_i arriving after reset release while in IDLE is ignored.
- States:
  - IDLE
    - No request: stay in IDLE.
    - One requester: grant it.
    - Both requesters: grant the side not granted last (round-robin).
    - On grant, register the winner's command/address/data onto mem_* the same cycle. mem_* is valid from the next cycle.
    - Next state is GNT_I or GNT_D.
  - GNT_I / GNT_D
    - mem_* is held stable, sourced from the registered copy. A change on upstream inputs is not reflected.
    - On mem_resp_i:
      - Drop mem_read_o/mem_write_o the next cycle.
      - Pass mem_rdata_i and the resp pulse combinationally to the granted port only. Its rdata is 0 otherwise.
      - Update the last-grant pointer and go to TURN.
  - TURN
    - Exactly one cycle, with no grant. The requester sees its resp and deasserts, so its stale level is never re-granted.
    - Next state is IDLE.
- Minimum latency: a request seen in IDLE at cycle N drives mem_* at N+1. A resp at cycle M gives a granted-port resp at M. The next grant is at M+2 at the earliest.
- i_resp_o and d_resp_o are never high together. The non-granted port's resp is always 0.
- mem_resp_i in IDLE or TURN is ignored.
- Watchdog, active when TIMEOUT > 0:
  - The counter clears on grant and increments each cycle in GNT_*.
  - When it reaches TIMEOUT:
    - Set timeout_o; it stays set until reset.
    - Force a resp pulse with rdata 0 to the granted port.
    - Drop the mem_* command and go to TURN.
- d_read_i and d_write_i both high: treated as a write.

Test Plan:
- Single I fetch: i_read_i=1, addr 0x100, memory answers 3 cycles after mem_read_o with 0xDEADBEEF -> mem_addr_o=0x100 one cycle after request; i_resp_o pulses once with i_rdata_o=0xDEADBEEF; d_resp_o stays 0; busy_o falls 2 cycles after the resp.
- Simultaneous first requests, D_FIRST=1: i_read_i and d_write_i both raised in cycle 0 (addr 0x200, wdata 0x12345678, mask 0xF) -> D is granted first with mem_write_o=1 and matching data; I is granted in the IDLE after TURN.
- Continuous contention: both ports re-request immediately after each resp for 8 accesses -> grants strictly alternate D,I,D,I...; neither port is granted twice in a row.
- Stale level: requester holds i_read_i high through the resp cycle and drops it the next cycle -> exactly one mem_read_o transaction, no duplicate grant.
- Timeout, TIMEOUT=15: memory never asserts mem_resp_i -> at the 15th GNT cycle timeout_o=1, the granted port's resp pulses with rdata 0; a following request is still served normally and timeout_o stays 1.
- Async reset mid-access: rst_i driven low in GNT_D between clock edges -> mem_write_o, busy_o and resp outputs go 0 immediately; after release, a late mem_resp_i produces no upstream resp.
